// File: rtl/rv32i_types.sv
// Types and defaults shared by the CDB-side blocks of the rv32i core.
package rv32i_types;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int NREQ_CDB = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_picker
  import rv32i_types::*;
#(
  parameter int NREQ = NREQ_CDB,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    logic found;
    int   pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Round-robin, burst-capable arbiter in front of a shared queue; also drives the consumer side.
// Optional source tagging of queue words is enabled by defining QUEUE_ARB_TAG_EN.
module queue_arbiter
  import rv32i_types::*;
#(
  parameter int NREQ  = NREQ_CDB,
  parameter int WIDTH = 32,
  parameter int BURST = 1,
  parameter int IDW   = $clog2(NREQ),
`ifdef QUEUE_ARB_TAG_EN
  parameter int QW    = WIDTH + IDW
`else
  parameter int QW    = WIDTH
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [QW-1:0]               q_wdata,
  output logic                        q_enqueue,
  input  logic                        q_is_full,
  input  logic [QW-1:0]               q_rdata,
  output logic                        q_dequeue,
  input  logic                        q_is_empty,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
`ifdef QUEUE_ARB_TAG_EN
  output logic [IDW-1:0]              out_tag,
`endif
  input  logic                        out_ready
);

  localparam int BW = $clog2(BURST + 1);

  arb_state_t      state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  owner;
  logic [BW-1:0]   bcnt;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            owner_valid;
  logic            hold_win;
  logic [IDW-1:0]  winner;
  logic            space;
  logic            grant_en;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
  endfunction

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Consumer side depends only on queue status, never on producer valids.
  assign out_valid = !q_is_empty && !rst;
  assign q_dequeue = out_valid && out_ready;
  assign out_data  = q_rdata[WIDTH-1:0];
`ifdef QUEUE_ARB_TAG_EN
  assign out_tag   = q_rdata[QW-1:WIDTH];
`endif

  assign space       = !q_is_full || q_dequeue;
  assign owner_valid = req_valid[owner];
  assign hold_win    = (state == HOLD) && owner_valid;
  assign winner      = hold_win ? owner : pick_idx;
  assign grant_en    = space && (|req_valid) && !rst;

  assign req_ready = !grant_en ? '0 :
                     hold_win  ? (NREQ'(1) << owner) : pick_gnt;
  assign q_enqueue = |(req_valid & req_ready);

`ifdef QUEUE_ARB_TAG_EN
  assign q_wdata = {winner, req_data[winner]};
`else
  assign q_wdata = req_data[winner];
`endif

  // A stalled cycle (no space) leaves the burst state untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      bcnt   <= '0;
    end else if (space) begin
      if (state == HOLD && !owner_valid) begin
        rr_ptr <= next_id(owner);
        state  <= IDLE;
      end
      if (q_enqueue) begin
        if (hold_win) begin
          bcnt <= bcnt + 1'b1;
          if (int'(bcnt) + 1 == BURST) begin
            rr_ptr <= next_id(owner);
            state  <= IDLE;
          end
        end else if (BURST == 1) begin
          rr_ptr <= next_id(winner);
          state  <= IDLE;
        end else begin
          owner <= winner;
          bcnt  <= BW'(1);
          state <= HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: a BURST=1 and a BURST=3 instance, each with a 4-deep queue model.
module tb_queue_arbiter;

`ifdef QUEUE_ARB_TAG_EN
  localparam int QW = 34;
`else
  localparam int QW = 32;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0][31:0] req_data;
  logic [3:0] rv1, rv3;
  logic ordy1, ordy3;

  logic [3:0]    rr1, rr3;
  logic [QW-1:0] wd1, wd3, rd1, rd3;
  logic          enq1, enq3, deq1, deq3, full1, full3, empty1, empty3, ov1, ov3;
  logic [31:0]   od1, od3;
`ifdef QUEUE_ARB_TAG_EN
  logic [1:0]    ot1, ot3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  queue_arbiter #(.NREQ(4), .WIDTH(32), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_data(req_data), .req_ready(rr1),
    .q_wdata(wd1), .q_enqueue(enq1), .q_is_full(full1), .q_rdata(rd1),
    .q_dequeue(deq1), .q_is_empty(empty1), .out_valid(ov1), .out_data(od1),
`ifdef QUEUE_ARB_TAG_EN
    .out_tag(ot1),
`endif
    .out_ready(ordy1)
  );

  queue_arbiter #(.NREQ(4), .WIDTH(32), .BURST(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_data(req_data), .req_ready(rr3),
    .q_wdata(wd3), .q_enqueue(enq3), .q_is_full(full3), .q_rdata(rd3),
    .q_dequeue(deq3), .q_is_empty(empty3), .out_valid(ov3), .out_data(od3),
`ifdef QUEUE_ARB_TAG_EN
    .out_tag(ot3),
`endif
    .out_ready(ordy3)
  );

  // Non-transparent 4-entry queue models (LENGTHEXP = 2)
  logic [QW-1:0] mem1 [4];
  logic [QW-1:0] mem3 [4];
  logic [2:0] cnt1, cnt3;
  logic [1:0] rp1, wp1, rp3, wp3;

  always @(posedge clk) begin
    if (rst) begin
      cnt1 <= '0; rp1 <= '0; wp1 <= '0;
    end else begin
      if (enq1) begin mem1[wp1] <= wd1; wp1 <= wp1 + 2'd1; end
      if (deq1) rp1 <= rp1 + 2'd1;
      cnt1 <= cnt1 + {2'b0, enq1} - {2'b0, deq1};
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt3 <= '0; rp3 <= '0; wp3 <= '0;
    end else begin
      if (enq3) begin mem3[wp3] <= wd3; wp3 <= wp3 + 2'd1; end
      if (deq3) rp3 <= rp3 + 2'd1;
      cnt3 <= cnt3 + {2'b0, enq3} - {2'b0, deq3};
    end
  end

  assign full1  = (cnt1 == 3'd4);
  assign empty1 = (cnt1 == 3'd0);
  assign rd1    = mem1[rp1];
  assign full3  = (cnt3 == 3'd4);
  assign empty3 = (cnt3 == 3'd0);
  assign rd3    = mem3[rp3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv1 = '0; rv3 = '0; ordy1 = 1'b0; ordy3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv1 = 4'b1111; rv3 = 4'b1111; ordy1 = 1'b1; ordy3 = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({rr1, enq1, deq1, ov1} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_b1: got rdy=%b enq=%b deq=%b ov=%b want all 0", rr1, enq1, deq1, ov1);
    end
    n_cmp++;
    if ({rr3, enq3, deq3, ov3} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_b3: got rdy=%b enq=%b deq=%b ov=%b want all 0", rr3, enq3, deq3, ov3);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_rdy;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'hC0DE_0000 | i;
    rv1 = 4'b1111; ordy1 = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 4'b0001 << exp_g[c];
      n_cmp++;
      if (rr1 !== exp_rdy || enq1 !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rr_grant c%0d: got rdy=%b enq=%b want rdy=%b enq=1", c, rr1, enq1, exp_rdy);
      end
      if (c > 0) begin
        exp_d = 32'hC0DE_0000 | exp_g[c-1];
        n_cmp++;
        if (ov1 !== 1'b1 || od1 !== exp_d) begin
          n_fail++;
          $display("[TB] FAIL rr_data c%0d: got ov=%b data=%h want ov=1 data=%h", c, ov1, od1, exp_d);
        end
      end
      tick();
    end
    rv1 = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    rv1 = 4'b0010; ordy1 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      req_data[1] = 32'h5000_0000 + b;
      #1;
      n_cmp++;
      if (rr1 !== 4'b0010 || enq1 !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL fill b%0d: got rdy=%b enq=%b want rdy=0010 enq=1", b, rr1, enq1);
      end
      tick();
    end
    req_data[1] = 32'h5000_0004;
    #1;
    n_cmp++;
    if (rr1 !== 4'b0000 || enq1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_stall: got rdy=%b enq=%b want rdy=0000 enq=0", rr1, enq1);
    end
    ordy1 = 1'b1;
    #1;
    n_cmp++;
    if (rr1 !== 4'b0010 || enq1 !== 1'b1 || deq1 !== 1'b1 || od1 !== 32'h5000_0000) begin
      n_fail++;
      $display("[TB] FAIL full_deq_grant: got rdy=%b enq=%b deq=%b data=%h want 0010 1 1 50000000",
               rr1, enq1, deq1, od1);
    end
    tick();
    rv1 = '0; ordy1 = 1'b0;
    #1;
    n_cmp++;
    if (cnt1 !== 3'd4 || od1 !== 32'h5000_0001) begin
      n_fail++;
      $display("[TB] FAIL full_occupancy: got cnt=%0d data=%h want cnt=4 data=50000001", cnt1, od1);
    end
  endtask

  task automatic test_empty_guard();
    do_reset();
    rv1 = '0; ordy1 = 1'b1;
    #1;
    n_cmp++;
    if (deq1 !== 1'b0 || ov1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL empty_guard: got deq=%b ov=%b want 0 0", deq1, ov1);
    end
    rv1 = 4'b0001; req_data[0] = 32'h1234_5678;
    #1;
    n_cmp++;
    if (enq1 !== 1'b1 || deq1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL empty_enq: got enq=%b deq=%b want 1 0", enq1, deq1);
    end
    tick();
    rv1 = '0;
    #1;
    n_cmp++;
    if (ov1 !== 1'b1 || deq1 !== 1'b1 || od1 !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL empty_next: got ov=%b deq=%b data=%h want 1 1 12345678", ov1, deq1, od1);
    end
    tick();
    n_cmp++;
    if (ov1 !== 1'b0 || deq1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL empty_drained: got ov=%b deq=%b want 0 0", ov1, deq1);
    end
  endtask

  task automatic test_burst();
    int exp_g [7] = '{0, 0, 0, 2, 2, 2, 0};
    logic [3:0] exp_rdy;
    do_reset();
    rv3 = 4'b0101; ordy3 = 1'b1;
    #1;
    for (int c = 0; c < 7; c++) begin
      exp_rdy = 4'b0001 << exp_g[c];
      n_cmp++;
      if (rr3 !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL burst_grant c%0d: got %b want %b", c, rr3, exp_rdy);
      end
      tick();
    end
    // requester 0 drops after two beats of a fresh burst
    do_reset();
    rv3 = 4'b0101; ordy3 = 1'b1;
    tick();
    tick();
    rv3 = 4'b0100;
    #1;
    n_cmp++;
    if (rr3 !== 4'b0100 || enq3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL burst_drop: got rdy=%b enq=%b want rdy=0100 enq=1", rr3, enq3);
    end
    tick();
    rv3 = 4'b0101;
    #1;
    n_cmp++;
    if (rr3 !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL burst_drop_hold: got %b want 0100", rr3);
    end
    tick();
    rv3 = '0;
  endtask

  task automatic test_tag();
    logic [QW-1:0] exp_w;
`ifdef QUEUE_ARB_TAG_EN
    exp_w = {2'd3, 32'hDEAD_BEEF};
`else
    exp_w = 32'hDEAD_BEEF;
`endif
    do_reset();
    rv1 = 4'b1000; req_data[3] = 32'hDEAD_BEEF; ordy1 = 1'b1;
    #1;
    n_cmp++;
    if (rr1 !== 4'b1000 || wd1 !== exp_w) begin
      n_fail++;
      $display("[TB] FAIL tag_wdata: got rdy=%b wdata=%h want rdy=1000 wdata=%h", rr1, wd1, exp_w);
    end
    tick();
    rv1 = '0;
    #1;
    n_cmp++;
    if (ov1 !== 1'b1 || od1 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL tag_data: got ov=%b data=%h want 1 deadbeef", ov1, od1);
    end
`ifdef QUEUE_ARB_TAG_EN
    n_cmp++;
    if (ot1 !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL tag_id: got %0d want 3", ot1);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rv3 = 4'b0100; ordy3 = 1'b1;
    #1;
    n_cmp++;
    if (rr3 !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL midrst_start: got %b want 0100", rr3);
    end
    tick();
    tick();
    rst = 1'b1; rv3 = 4'b1111;
    #1;
    n_cmp++;
    if ({rr3, enq3, deq3, ov3} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got rdy=%b enq=%b deq=%b ov=%b want all 0", rr3, enq3, deq3, ov3);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rr3 !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL midrst_first_grant: got %b want 0001", rr3);
    end
    tick();
    rv3 = '0;
  endtask

  initial begin
    rst = 1'b1; rv1 = '0; rv3 = '0; ordy1 = 1'b0; ordy3 = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    $display("[TB] starting queue_arbiter bench");
    test_reset();
    test_round_robin();
    test_full_stall();
    test_empty_guard();
    test_burst();
    test_tag();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
